// File: rtl/image_read_proc.sv
// ---------------------------------------------------------------------------
// image_read_proc
//   Frame source and pixel-processing stage feeding a BMP image writer.
//   On start it scans a frame memory through two synchronous read ports
//   (two pixels per clock), applies a saturating brightness offset to every
//   byte and emits the result raster-timed: a vsync window, then one hsync
//   burst per row. Rows are scanned bottom-up to match BMP row order.
//
// Optional feature (compile-time macro INVERT_EN):
//   defined   - each saturated byte is replaced by 255-out in the same
//               register stage (latency unchanged)
//   undefined - saturated byte is output directly
//
// Ports:
//   HCLK        in   clock, rising edge
//   HRESETn     in   asynchronous active-low reset
//   start       in   one-cycle frame request, sampled only in IDLE
//   mem_addr0   out  even-pixel read address (0 outside DATA)
//   mem_addr1   out  odd-pixel read address = mem_addr0+1 (0 outside DATA)
//   mem_rdata0  in   {R,G,B} for mem_addr0, valid one cycle after address
//   mem_rdata1  in   {R,G,B} for mem_addr1, valid one cycle after address
//   vsync       out  frame start-up window
//   hsync       out  processed pixel-pair valid strobe
//   DATA_R0/G0/B0  out  processed even pixel bytes
//   DATA_R1/G1/B1  out  processed odd pixel bytes
//   busy        out  high from the cycle after start is accepted until done
//   frame_done  out  one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module image_read_proc #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int ADDR_W         = 19,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160,
    parameter int VALUE          = 100,
    parameter int SIGN           = 1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [ADDR_W-1:0] mem_addr1,
    input  logic [23:0]       mem_rdata0,
    input  logic [23:0]       mem_rdata1,
    output logic              vsync,
    output logic              hsync,
    output logic [7:0]        DATA_R0,
    output logic [7:0]        DATA_G0,
    output logic [7:0]        DATA_B0,
    output logic [7:0]        DATA_R1,
    output logic [7:0]        DATA_G1,
    output logic [7:0]        DATA_B1,
    output logic              busy,
    output logic              frame_done
);

    localparam int LP_HALF_W  = WIDTH / 2;
    localparam int LP_CNT_MAX = (START_UP_DELAY > HSYNC_DELAY)
                              ? ((START_UP_DELAY > LP_HALF_W) ? START_UP_DELAY : LP_HALF_W)
                              : ((HSYNC_DELAY > LP_HALF_W) ? HSYNC_DELAY : LP_HALF_W);
    localparam int CNT_W      = $clog2(LP_CNT_MAX + 2);

    localparam logic [CNT_W-1:0] LP_VS_LAST   = CNT_W'((START_UP_DELAY > 0) ? START_UP_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] LP_HS_LAST   = CNT_W'((HSYNC_DELAY > 0) ? HSYNC_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] LP_DATA_LAST = CNT_W'(LP_HALF_W - 1);
    localparam logic [CNT_W-1:0] LP_FLUSH_LAST = CNT_W'(1);

    localparam logic [ADDR_W-1:0] LP_ROW_STEP = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LP_TOP_BASE = ADDR_W'((HEIGHT - 1) * WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_HSYNC,
        S_DATA,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            w_row_entry;   // first state of a row's sequence
    logic              w_step_end;    // current timed step finishes this cycle
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_base;        // address of pixel 0 of the current row
    logic [ADDR_W-1:0] r_addr;        // even-pixel address of the current pair
    logic              r_v1;          // read data valid on mem_rdata* this cycle
    logic              r_hsync;
    logic [7:0]        r_r0, r_g0, r_b0, r_r1, r_g1, r_b1;

    // 9-bit saturating offset, optional inversion after saturation.
    function automatic logic [7:0] f_proc(input logic [7:0] x);
        logic [8:0] s;
        logic [7:0] y;
        if (SIGN != 0) begin
            s = {1'b0, x} + 9'(VALUE);
            y = s[8] ? 8'hFF : s[7:0];
        end else begin
            // borrow into bit 8 marks a negative result
            s = {1'b0, x} - 9'(VALUE);
            y = s[8] ? 8'h00 : s[7:0];
        end
`ifdef INVERT_EN
        y = ~y;
`endif
        return y;
    endfunction

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_step_end  = 1'b0;
        w_row_entry = (HSYNC_DELAY == 0) ? S_DATA : S_HSYNC;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_step_end  = 1'b1;
                    w_state_nxt = (START_UP_DELAY == 0) ? w_row_entry : S_VSYNC;
                end
            end
            S_VSYNC: begin
                if (r_cnt == LP_VS_LAST) begin
                    w_step_end  = 1'b1;
                    w_state_nxt = w_row_entry;
                end
            end
            S_HSYNC: begin
                if (r_cnt == LP_HS_LAST) begin
                    w_step_end  = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == LP_DATA_LAST) begin
                    w_step_end  = 1'b1;
                    w_state_nxt = (r_base == '0) ? S_FLUSH : w_row_entry;
                end
            end
            S_FLUSH: begin
                if (r_cnt == LP_FLUSH_LAST) begin
                    w_step_end  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // start arriving here is dropped; it must be re-issued in IDLE
                w_step_end  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Step counter and row/pair address generation
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt  <= '0;
            r_base <= '0;
            r_addr <= '0;
        end else begin
            if (r_state == S_IDLE || w_step_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (r_state == S_IDLE && start) begin
                r_base <= LP_TOP_BASE;
                r_addr <= LP_TOP_BASE;
            end else if (r_state == S_DATA) begin
                if (w_step_end) begin
                    // move up one row in memory (down one row in the image)
                    r_base <= r_base - LP_ROW_STEP;
                    r_addr <= r_base - LP_ROW_STEP;
                end else begin
                    r_addr <= r_addr + ADDR_W'(2);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read/process pipeline: address at t, rdata at t+1, outputs at t+2
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_v1    <= 1'b0;
            r_hsync <= 1'b0;
            r_r0    <= '0;
            r_g0    <= '0;
            r_b0    <= '0;
            r_r1    <= '0;
            r_g1    <= '0;
            r_b1    <= '0;
        end else begin
            r_v1    <= (r_state == S_DATA);
            r_hsync <= r_v1;
            if (r_v1) begin
                r_r0 <= f_proc(mem_rdata0[23:16]);
                r_g0 <= f_proc(mem_rdata0[15:8]);
                r_b0 <= f_proc(mem_rdata0[7:0]);
                r_r1 <= f_proc(mem_rdata1[23:16]);
                r_g1 <= f_proc(mem_rdata1[15:8]);
                r_b1 <= f_proc(mem_rdata1[7:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr0  = (r_state == S_DATA) ? r_addr : '0;
    assign mem_addr1  = (r_state == S_DATA) ? (r_addr + ADDR_W'(1)) : '0;
    assign vsync      = (r_state == S_VSYNC);
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign frame_done = (r_state == S_DONE);
    assign hsync      = r_hsync;
    assign DATA_R0    = r_r0;
    assign DATA_G0    = r_g0;
    assign DATA_B0    = r_b0;
    assign DATA_R1    = r_r1;
    assign DATA_G1    = r_g1;
    assign DATA_B1    = r_b1;

endmodule

// File: tb/tb_image_read_proc.sv
module tb_image_read_proc;

    localparam int AW = 4;

`ifdef INVERT_EN
    localparam logic [47:0] INV_MASK = '1;
`else
    localparam logic [47:0] INV_MASK = '0;
`endif

    // Hand-computed {R0,G0,B0,R1,G1,B1} per burst beat.
    // Beat order: pair (4,5), (6,7) of row 1, then (0,1), (2,3) of row 0.
    localparam logic [47:0] EXP_ADD [4] = '{
        48'h74FF96_64FFC8,
        48'hFFC9FF_84A4C4,
        48'hFF7464_FFFF96,
        48'hC8C9FF_65E4FF
    };
    localparam logic [47:0] EXP_SUB [4] = '{
        48'h006400_009B00,
        48'h370138_000000,
        48'h640000_373800,
        48'h00019B_001C9A
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [23:0] mem [8];

    // adder instance
    logic [AW-1:0] a_addr0, a_addr1;
    logic [23:0]   a_rd0, a_rd1;
    logic          a_vs, a_hs, a_busy, a_done;
    logic [7:0]    a_r0, a_g0, a_b0, a_r1, a_g1, a_b1;
    // subtractor instance
    logic [AW-1:0] s_addr0, s_addr1;
    logic [23:0]   s_rd0, s_rd1;
    logic          s_vs, s_hs, s_busy, s_done;
    logic [7:0]    s_r0, s_g0, s_b0, s_r1, s_g1, s_b1;

    always @(posedge clk) begin
        a_rd0 <= mem[a_addr0[2:0]];
        a_rd1 <= mem[a_addr1[2:0]];
        s_rd0 <= mem[s_addr0[2:0]];
        s_rd1 <= mem[s_addr1[2:0]];
    end

    image_read_proc #(
        .WIDTH(4), .HEIGHT(2), .ADDR_W(AW), .START_UP_DELAY(3),
        .HSYNC_DELAY(2), .VALUE(100), .SIGN(1)
    ) u_add (
        .HCLK(clk), .HRESETn(rst_n), .start(start),
        .mem_addr0(a_addr0), .mem_addr1(a_addr1),
        .mem_rdata0(a_rd0), .mem_rdata1(a_rd1),
        .vsync(a_vs), .hsync(a_hs),
        .DATA_R0(a_r0), .DATA_G0(a_g0), .DATA_B0(a_b0),
        .DATA_R1(a_r1), .DATA_G1(a_g1), .DATA_B1(a_b1),
        .busy(a_busy), .frame_done(a_done)
    );

    image_read_proc #(
        .WIDTH(4), .HEIGHT(2), .ADDR_W(AW), .START_UP_DELAY(3),
        .HSYNC_DELAY(2), .VALUE(100), .SIGN(0)
    ) u_sub (
        .HCLK(clk), .HRESETn(rst_n), .start(start),
        .mem_addr0(s_addr0), .mem_addr1(s_addr1),
        .mem_rdata0(s_rd0), .mem_rdata1(s_rd1),
        .vsync(s_vs), .hsync(s_hs),
        .DATA_R0(s_r0), .DATA_G0(s_g0), .DATA_B0(s_b0),
        .DATA_R1(s_r1), .DATA_G1(s_g1), .DATA_B1(s_b1),
        .busy(s_busy), .frame_done(s_done)
    );

    int checks = 0;
    int errors = 0;
    logic [47:0] last_add = '0;
    logic [47:0] last_sub = '0;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a_ctl"}, {44'd0, a_vs, a_hs, a_busy, a_done}, 48'd0);
        chk({tag, ".a_addr"}, {40'd0, a_addr0, a_addr1}, 48'd0);
        chk({tag, ".a_data"}, {a_r0, a_g0, a_b0, a_r1, a_g1, a_b1}, 48'd0);
        chk({tag, ".s_ctl"}, {44'd0, s_vs, s_hs, s_busy, s_done}, 48'd0);
        chk({tag, ".s_addr"}, {40'd0, s_addr0, s_addr1}, 48'd0);
        chk({tag, ".s_data"}, {s_r0, s_g0, s_b0, s_r1, s_g1, s_b1}, 48'd0);
    endtask

    // Expected timeline relative to the start pulse in cycle 0.
    task automatic check_cycle(input string tag, input int c);
        logic ev, eh, eb, ef;
        logic [AW-1:0] ea0, ea1;
        int beat;
        string t;
        t    = $sformatf("%s.c%0d", tag, c);
        ev   = (c >= 1 && c <= 3);
        eb   = (c >= 1 && c <= 13);
        ef   = (c == 14);
        eh   = (c == 8 || c == 9 || c == 12 || c == 13);
        ea0  = '0;
        ea1  = '0;
        case (c)
            6:  begin ea0 = 4'd4; ea1 = 4'd5; end
            7:  begin ea0 = 4'd6; ea1 = 4'd7; end
            10: begin ea0 = 4'd0; ea1 = 4'd1; end
            11: begin ea0 = 4'd2; ea1 = 4'd3; end
            default: ;
        endcase
        if (eh) begin
            beat = (c == 8) ? 0 : (c == 9) ? 1 : (c == 12) ? 2 : 3;
            last_add = EXP_ADD[beat] ^ INV_MASK;
            last_sub = EXP_SUB[beat] ^ INV_MASK;
        end
        chk({t, ".ctl"}, {44'd0, a_vs, a_hs, a_busy, a_done}, {44'd0, ev, eh, eb, ef});
        chk({t, ".addr"}, {40'd0, a_addr0, a_addr1}, {40'd0, ea0, ea1});
        chk({t, ".add"}, {a_r0, a_g0, a_b0, a_r1, a_g1, a_b1}, last_add);
        chk({t, ".s_ctl"}, {44'd0, s_vs, s_hs, s_busy, s_done}, {44'd0, ev, eh, eb, ef});
        chk({t, ".sub"}, {s_r0, s_g0, s_b0, s_r1, s_g1, s_b1}, last_sub);
    endtask

    // Caller is just after a rising edge with both DUTs idle.
    // extra_starts re-pulses start during VSYNC (c2), DATA (c7) and DONE (c14).
    task automatic run_frame(input string tag, input bit extra_starts);
        for (int c = 0; c <= 16; c++) begin
            start = (c == 0) || (extra_starts && (c == 2 || c == 7 || c == 14));
            @(negedge clk);
            check_cycle(tag, c);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 24'hC81000;
        mem[1] = 24'h9B9C32;
        mem[2] = 24'h6465FF;
        mem[3] = 24'h0180FE;
        mem[4] = 24'h10C832;
        mem[5] = 24'h00FF64;
        mem[6] = 24'h9B659C;
        mem[7] = 24'h204060;

        // reset state
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // nominal frame
        run_frame("f1", 1'b0);

        // start during VSYNC, DATA and DONE must all be ignored
        run_frame("f2", 1'b1);

        // abort during the row-1 DATA burst (cycle 7)
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort.pre_addr", {44'd0, a_addr0}, {44'd0, 4'd6});
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        last_add = '0;
        last_sub = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full frame after abort
        run_frame("f3", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_read_proc.md
Name: image_read_proc

Overview:
- Frame source and pixel-processing stage that feeds the BMP image writer directly.
- On `start`, it scans a frame memory through two synchronous read ports, two pixels per clock.
- Each byte gets a saturating brightness adjustment.
- Output is raster-timed: `vsync`, then one `hsync` burst per row, with R0/G0/B0 and R1/G1/B1 byte pairs.
- Rows are emitted bottom-up, matching BMP row order.

Parameters:
- WIDTH, 768: pixels per row; must be even and ≥2.
- HEIGHT, 512: rows per frame; ≥1.
- ADDR_W, 19: frame-memory address width; WIDTH*HEIGHT ≤ 2^ADDR_W.
- START_UP_DELAY, 100: cycles `vsync` is held high before the first row.
- HSYNC_DELAY, 160: idle gap in cycles before each row's read burst.
- VALUE, 100: brightness offset, 0..255.
- SIGN, 1: 1 adds VALUE, 0 subtracts it.

Ports:
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- mem_addr0  out  ADDR_W  even-pixel read address.
- mem_addr1  out  ADDR_W  odd-pixel read address (mem_addr0+1).
- mem_rdata0  in  24  {R,G,B} for mem_addr0; valid one cycle after the address.
- mem_rdata1  in  24  {R,G,B} for mem_addr1; valid one cycle after the address.
- vsync  out  1  frame start-up window.
- hsync  out  1  pixel-pair valid strobe.
- DATA_R0  out  8  processed even pixel, red.
- DATA_G0  out  8  processed even pixel, green.
- DATA_B0  out  8  processed even pixel, blue.
- DATA_R1  out  8  processed odd pixel, red.
- DATA_G1  out  8  processed odd pixel, green.
- DATA_B1  out  8  processed odd pixel, blue.
- busy  out  1  high from the cycle after `start` is accepted until `frame_done`.
- frame_done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset: all outputs are 0, FSM in IDLE, all counters cleared. Reset asserted mid-frame aborts immediately; no `frame_done` pulse is produced.
- States and transitions:
  - IDLE: `start`=1 moves to VSYNC; `busy`=1 from the next cycle.
  - VSYNC: `vsync`=1 for exactly START_UP_DELAY cycles, then HSYNC.
  - HSYNC: idle for HSYNC_DELAY cycles, then DATA. If HSYNC_DELAY=0, go straight to DATA.
  - DATA: exactly WIDTH/2 cycles.
    - Each cycle issues one pixel pair: mem_addr0 = row*WIDTH + 2k, mem_addr1 = mem_addr0 + 1, for k = 0..WIDTH/2-1.
    - After the pair with k = WIDTH/2-1: if the current row is 0, go to FLUSH; otherwise decrement the row and go to HSYNC.
  - FLUSH: 2 cycles to drain the pipeline, then DONE.
  - DONE: `frame_done`=1 and `busy`=0 in this cycle, then IDLE.
- Row order: HEIGHT-1 first, down to 0.
- Address generation: use a base register decremented by WIDTH per row; no multiplier.
- Outside DATA, mem_addr0 and mem_addr1 are driven to 0.
- Pipeline latency: address issued in cycle t, rdata sampled at t+1, processed bytes and `hsync`=1 registered at t+2.
  - `hsync` is high exactly WIDTH/2 consecutive cycles per row and HEIGHT bursts per frame.
  - DATA_* hold their last value while `hsync`=0.
- `vsync` and `hsync` are never high in the same cycle.
- Arithmetic, per byte x, in 9 bits:
  - SIGN=1: out = min(x+VALUE, 255).
  - SIGN=0: out = max(x−VALUE, 0).
- Byte mapping: R = rdata[23:16], G = rdata[15:8], B = rdata[7:0].
- `start` while `busy`=1 is ignored.
- `start` in the same cycle as DONE is ignored; it is accepted the next cycle in IDLE.
- The final `hsync` cycle is followed exactly one cycle later by `frame_done`.

Optional Feature:
- Macro: INVERT_EN.
- Defined: each byte is replaced by 255−out after saturation, in the same register stage; latency is unchanged.
- Undefined: the saturated value is output directly; no inversion logic is synthesized.

Test Plan:
Bench setup: WIDTH=4, HEIGHT=2, START_UP_DELAY=3, HSYNC_DELAY=2.
- Timing: `start` pulse at cycle 0.
  - `vsync` high cycles 1–3.
  - Row-1 addresses (4,5) and (6,7) issued cycles 6–7; `hsync` high cycles 8–9.
  - Row-0 addresses (0,1) and (2,3) issued cycles 10–11; `hsync` high cycles 12–13.
  - `frame_done` at cycle 14; `busy` high cycles 1–13.
- Add saturation: SIGN=1, VALUE=100; mem byte 0xC8 → 0xFF; 0x10 → 0x74.
- Subtract saturation: SIGN=0, VALUE=100; byte 0x32 → 0x00; 0xC8 → 0x64.
- Ignored start: `start` re-pulsed during VSYNC and during DATA → no restart; exactly one `frame_done`, 2 `hsync` bursts of 2 cycles each.
- Abort: HRESETn low during the row-1 DATA burst → all outputs 0 asynchronously. A new `start` after release yields a full, correct frame.
- INVERT_EN defined: SIGN=1, VALUE=100, input 0x10 → output 0x8B; pipeline timing identical to the first scenario.
